fp_mult_pipe: RTL and testbench
===============================

FP_MULT_PIPE -- requirements
Module: fp_mult_pipe

Interface
REQ-001 Parameter EXP_W, default 8, SHALL set exponent field width.
REQ-002 Parameter MAN_W, default 23, SHALL set stored mantissa field width; word width W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL mark the operand pair a/b as valid.
REQ-006 in_ready  output  1  SHALL indicate that the block accepts an operand pair this cycle.
REQ-007 a, b  input  W  SHALL carry the IEEE-754-format operands.
REQ-008 out_valid  output  1  SHALL mark the result as valid.
REQ-009 out_ready  input  1  SHALL indicate that the downstream block accepts the result.
REQ-010 result  output  W  SHALL carry the packed product.
REQ-011 flags  output  4  SHALL carry {invalid, overflow, underflow, inexact}, aligned with result.

Function
REQ-012 The block SHALL be a 3-stage pipeline: S1 unpack, classify, exponent sum, full (MAN_W+1)x(MAN_W+1) product; S2 normalise (1-bit shift) and guard/round/sticky; S3 round, overflow/underflow check, pack.
REQ-013 Transfer SHALL occur on in_valid&&in_ready (input) and out_valid&&out_ready (output).
REQ-014 in_ready SHALL equal !out_valid || out_ready; when it is low, every stage SHALL hold its contents (global stall).
REQ-015 Latency SHALL be exactly 3 cycles from accept to out_valid with no stall; sustained throughput SHALL be 1 result per cycle.
REQ-016 Bubbles SHALL propagate as invalid stages; each stage SHALL carry its own valid bit.
REQ-017 Sign SHALL be a[W-1]^b[W-1] for all non-NaN results.
REQ-018 Biased exponent SHALL be ea+eb-BIAS (BIAS = 2^(EXP_W-1)-1), computed EXP_W+2 bits wide and signed, then incremented when the product MSB is set, and incremented again on rounding carry-out.
REQ-019 Subnormal inputs SHALL be treated as zero (flush-to-zero); subnormal results SHALL be flushed to signed zero with underflow=1 and inexact=1.
REQ-020 A final exponent >= 2^EXP_W-1 SHALL give signed infinity with overflow=1 and inexact=1.
REQ-021 Any NaN input SHALL give the canonical quiet NaN (0, all-ones exponent, mantissa MSB=1, rest 0); inf*0 SHALL give the canonical quiet NaN with invalid=1.
REQ-022 inf*finite-nonzero SHALL give signed infinity with flags 0; zero*finite SHALL give signed zero with flags 0.
REQ-023 inexact SHALL be set whenever any discarded product bit is nonzero.
REQ-024 An output held under stall SHALL remain stable (result and flags unchanged) until accepted.

Reset
REQ-025 Assertion of reset_n=0 SHALL immediately clear all stage valid bits; out_valid SHALL be 0, result SHALL be 0 and flags SHALL be 0.
REQ-026 In-flight operations SHALL be discarded on reset and never emitted; in_ready SHALL be 1 in the first cycle after deassertion.

Configuration
REQ-027 With macro FP_MULT_RNE_EN defined, S3 SHALL round to nearest, ties to even, using guard, round and sticky bits.
REQ-028 Without FP_MULT_RNE_EN, S3 SHALL truncate (round toward zero); inexact is still reported, and overflow SHALL saturate to the largest finite value instead of infinity.

Verification
REQ-029 a=0x3FC00000, b=0x40000000, out_ready=1 -> result 0x40400000, flags 0, out_valid exactly 3 cycles after accept.
REQ-030 a=0x3F800001, b=0x3FC00000 -> result 0x3FC00002 with FP_MULT_RNE_EN, 0x3FC00001 without; inexact=1 in both builds.
REQ-031 a=0x7F000000, b=0x7F000000 -> 0x7F800000 with overflow=1 and inexact=1 (RNE build), 0x7F7FFFFF without; a=0x7F800000, b=0x00000000 -> 0x7FC00000 with invalid=1.
REQ-032 Issue 5 back-to-back ops and hold out_ready=0 for 4 cycles starting at the first out_valid -> in_ready=0 during the stall, no result lost or duplicated, results emitted in order, first result stable throughout.
REQ-033 Issue 2 ops, then pulse reset_n low 1 cycle later -> out_valid=0 immediately, neither op emitted, a new op after release completes in 3 cycles.
REQ-034 a=0x00800000, b=0x00800000 -> 0x00000000 with underflow=1 and inexact=1; a=0x00000001 (subnormal), b=0x3F800000 -> 0x00000000 with flags 0.

Source files
------------

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage IEEE-754-format floating-point multiplier.
// Uses a valid/ready handshake on both sides. A single global stall freezes every stage.
// Subnormal inputs and subnormal results are flushed to zero.
// Build option FP_MULT_RNE_EN: when defined, rounding is to nearest with ties to even and
// overflow gives infinity. When undefined, the result is truncated and overflow saturates
// to the largest finite value.

module fp_mult_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);

    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned SW = MAN_W + 1;       // significand incl. hidden bit
    localparam int unsigned PW = 2 * SW;          // full product width
    localparam int unsigned XW = EXP_W + 2;       // signed working exponent width

    localparam logic [XW-1:0]    BIAS    = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic [XW-1:0]    EXP_INF = XW'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'((1 << EXP_W) - 2);

    // Whole pipeline advances only when the output register is free or being drained
    assign in_ready = !out_valid || out_ready;

    // ---------------- S1: unpack, classify, exponent sum, product ----------------
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic             c_invalid, c_nan, c_inf, c_zero;

    assign ea = a[W-2:MAN_W];
    assign eb = b[W-2:MAN_W];
    assign fa = a[MAN_W-1:0];
    assign fb = b[MAN_W-1:0];

    // Zero exponent covers both true zero and flushed subnormals
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_MAX) && (fa == '0);
    assign b_inf  = (eb == EXP_MAX) && (fb == '0);
    assign a_nan  = (ea == EXP_MAX) && (fa != '0);
    assign b_nan  = (eb == EXP_MAX) && (fb != '0);

    assign c_invalid = !a_nan && !b_nan && ((a_inf && b_zero) || (a_zero && b_inf));
    assign c_nan     = a_nan || b_nan || c_invalid;
    assign c_inf     = !c_nan && (a_inf || b_inf);
    assign c_zero    = !c_nan && !c_inf && (a_zero || b_zero);

    logic          s1_valid, s1_sign, s1_nan, s1_invalid, s1_inf, s1_zero;
    logic [XW-1:0] s1_exp;
    logic [PW-1:0] s1_prod;

    // Stage 1 register: capture classification, biased exponent sum and raw product
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_nan     <= 1'b0;
            s1_invalid <= 1'b0;
            s1_inf     <= 1'b0;
            s1_zero    <= 1'b0;
            s1_exp     <= '0;
            s1_prod    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign    <= a[W-1] ^ b[W-1];
                s1_nan     <= c_nan;
                s1_invalid <= c_invalid;
                s1_inf     <= c_inf;
                s1_zero    <= c_zero;
                s1_exp     <= {2'b00, ea} + {2'b00, eb} - BIAS;
                s1_prod    <= PW'({1'b1, fa}) * PW'({1'b1, fb});
            end
        end
    end

    // ---------------- S2: normalise and extract guard/round/sticky ----------------
    logic [PW-1:0] norm;

    // Product of two [1,2) values lies in [1,4); shift left once when below 2
    assign norm = s1_prod[PW-1] ? s1_prod : {s1_prod[PW-2:0], 1'b0};

    logic          s2_valid, s2_sign, s2_nan, s2_invalid, s2_inf, s2_zero;
    logic [XW-1:0] s2_exp;
    logic [SW-1:0] s2_sig;
    logic          s2_guard, s2_round, s2_sticky;

    // Stage 2 register: normalised significand plus rounding bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid   <= 1'b0;
            s2_sign    <= 1'b0;
            s2_nan     <= 1'b0;
            s2_invalid <= 1'b0;
            s2_inf     <= 1'b0;
            s2_zero    <= 1'b0;
            s2_exp     <= '0;
            s2_sig     <= '0;
            s2_guard   <= 1'b0;
            s2_round   <= 1'b0;
            s2_sticky  <= 1'b0;
        end else if (in_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign    <= s1_sign;
                s2_nan     <= s1_nan;
                s2_invalid <= s1_invalid;
                s2_inf     <= s1_inf;
                s2_zero    <= s1_zero;
                s2_exp     <= s1_exp + {{(XW-1){1'b0}}, s1_prod[PW-1]};
                s2_sig     <= norm[PW-1 -: SW];
                s2_guard   <= norm[PW-1-SW];
                s2_round   <= norm[PW-2-SW];
                s2_sticky  <= |norm[PW-3-SW:0];
            end
        end
    end

    // ---------------- S3: round, range check, pack ----------------
    logic          round_up, carry, lost;
    logic [SW:0]   sig_rnd;
    logic [MAN_W-1:0] frac;
    logic [XW-1:0] exp_fin;
    logic [W-1:0]  res_d;
    logic [3:0]    flags_d;

`ifdef FP_MULT_RNE_EN
    assign round_up = s2_guard && (s2_round || s2_sticky || s2_sig[0]);
`else
    assign round_up = 1'b0;
`endif

    assign sig_rnd = {1'b0, s2_sig} + {{SW{1'b0}}, round_up};
    assign carry   = sig_rnd[SW];
    // On carry-out the significand is exactly 2.0, so the fraction is all zeros
    assign frac    = carry ? sig_rnd[SW-1:1] : sig_rnd[MAN_W-1:0];
    assign exp_fin = s2_exp + {{(XW-1){1'b0}}, carry};
    assign lost    = s2_guard || s2_round || s2_sticky;

    // Select special-case, overflow, underflow or normal packed result
    always_comb begin
        res_d   = {s2_sign, exp_fin[EXP_W-1:0], frac};
        flags_d = {3'b000, lost};
        if (s2_nan) begin
            res_d   = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
            flags_d = {s2_invalid, 3'b000};
        end else if (s2_inf) begin
            res_d   = {s2_sign, EXP_MAX, {MAN_W{1'b0}}};
            flags_d = 4'b0000;
        end else if (s2_zero) begin
            res_d   = {s2_sign, {(W-1){1'b0}}};
            flags_d = 4'b0000;
        end else if (!exp_fin[XW-1] && (exp_fin >= EXP_INF)) begin
`ifdef FP_MULT_RNE_EN
            res_d   = {s2_sign, EXP_MAX, {MAN_W{1'b0}}};
`else
            res_d   = {s2_sign, EXP_TOP, {MAN_W{1'b1}}};
`endif
            flags_d = 4'b0101;
        end else if (exp_fin[XW-1] || (exp_fin == '0)) begin
            res_d   = {s2_sign, {(W-1){1'b0}}};
            flags_d = 4'b0011;
        end
    end

    // Output register: held unchanged while downstream stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (in_ready) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                result <= res_d;
                flags  <= flags_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: directed vectors, stall and reset sequences, and a randomized stream
// checked against an arithmetic reference model (binary32 configuration).

module tb_fp_mult_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    logic [35:0] exp_q[$];
    logic [31:0] sq_a[$], sq_b[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [35:0] want;   // {flags, result}
    } vec_t;

    vec_t vecs[$];

    fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Reference: exact integer product, then round by comparing the remainder to half an ulp
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
        logic            s;
        int              ex, ey, e, sh;
        longint unsigned fx, fy, p, q, rem, half;
        bit              nx, ny, ix, iy, zx, zy, inexact;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        nx = (ex == 255) && (x[22:0] != 0);
        ny = (ey == 255) && (y[22:0] != 0);
        ix = (ex == 255) && (x[22:0] == 0);
        iy = (ey == 255) && (y[22:0] == 0);
        zx = (ex == 0);
        zy = (ey == 0);
        if (nx || ny) return {4'b0000, 32'h7FC00000};
        if ((ix && zy) || (zx && iy)) return {4'b1000, 32'h7FC00000};
        if (ix || iy) return {4'b0000, s, 8'hFF, 23'h0};
        if (zx || zy) return {4'b0000, s, 31'h0};
        fx = 64'(x[22:0]) + (64'd1 << 23);
        fy = 64'(y[22:0]) + (64'd1 << 23);
        p  = fx * fy;
        sh = (p >= (64'd1 << 47)) ? 24 : 23;
        q  = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        e  = ex + ey - 127 + sh - 23;
        inexact = (rem != 0);
`ifdef FP_MULT_RNE_EN
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
`endif
        if (e >= 255) begin
`ifdef FP_MULT_RNE_EN
            return {4'b0101, s, 8'hFF, 23'h0};
`else
            return {4'b0101, s, 8'hFE, 23'h7FFFFF};
`endif
        end
        if (e <= 0) return {4'b0011, s, 31'h0};
        return {3'b000, inexact, s, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        int          k;
        logic [7:0]  e;
        logic [22:0] f;
        k = $urandom_range(0, 9);
        f = 23'($urandom);
        case (k)
            0:       e = 8'h00;
            1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 1) f = '0; end
            6:       e = 8'($urandom_range(190, 254));
            7:       e = 8'($urandom_range(1, 60));
            8:       e = 8'($urandom);
            9:       begin e = 8'($urandom_range(110, 144)); f = f & 23'h7FF000; end
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), e, f};
    endfunction

    // One isolated operation: checks acceptance, 3-cycle latency and the packed output
    task automatic single(input logic [31:0] x, input logic [31:0] y, input logic [35:0] want,
                          input string name);
        int lat;
        out_ready = 1'b1;
        a = x;
        b = y;
        in_valid = 1'b1;
        check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'd3);
        check(name, 64'({flags, result}), 64'(want));
        @(posedge clk); #1;
    endtask

    // Streams sq_a/sq_b through the DUT against a scoreboard.
    // stall_mode: back-to-back issue with a 4-cycle out_ready hold at the first result.
    task automatic run_stream(input int n, input bit stall_mode);
        int          sent, got, cyc, stall_left;
        bit          seen, in_fire, out_fire;
        logic [35:0] first_want, w;
        sent = 0;
        got = 0;
        cyc = 0;
        stall_left = 0;
        seen = 0;
        first_want = '0;
        exp_q.delete();
        a = sq_a[0];
        b = sq_b[0];
        in_valid = stall_mode || ($urandom_range(0, 3) != 0);
        while ((sent < n || got < n) && cyc < 5000) begin
            @(negedge clk);
            if (stall_mode) begin
                if (out_valid && !seen) begin
                    seen = 1;
                    stall_left = 4;
                    first_want = exp_q[0];
                end
                out_ready = (stall_left == 0);
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            #1;
            if (stall_mode && stall_left > 0) begin
                check("stall_in_ready", 64'(in_ready), 64'd0);
                check("stall_out_valid", 64'(out_valid), 64'd1);
                check("stall_hold", 64'({flags, result}), 64'(first_want));
                stall_left--;
            end
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                if (exp_q.size() == 0) begin
                    check("stream_spurious", 64'(got), 64'(n + 1));
                end else begin
                    w = exp_q.pop_front();
                    check(stall_mode ? "stall_result" : "stream_result",
                          64'({flags, result}), 64'(w));
                end
                got++;
            end
            if (in_fire) begin
                exp_q.push_back(model(a, b));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (sent < n) begin
                a = sq_a[sent];
                b = sq_b[sent];
            end
            in_valid = (sent < n) && (stall_mode || ($urandom_range(0, 3) != 0));
        end
        check(stall_mode ? "stall_count" : "stream_count", 64'(got), 64'(n));
        if (stall_mode) check("stall_seen", 64'(seen), 64'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        bit saw_valid;

        // Directed vectors: {a, b, {flags, result}}
        vecs.push_back('{32'h3FC00000, 32'h40000000, {4'b0000, 32'h40400000}});
`ifdef FP_MULT_RNE_EN
        vecs.push_back('{32'h3F800001, 32'h3FC00000, {4'b0001, 32'h3FC00002}});
        vecs.push_back('{32'h7F000000, 32'h7F000000, {4'b0101, 32'h7F800000}});
`else
        vecs.push_back('{32'h3F800001, 32'h3FC00000, {4'b0001, 32'h3FC00001}});
        vecs.push_back('{32'h7F000000, 32'h7F000000, {4'b0101, 32'h7F7FFFFF}});
`endif
        vecs.push_back('{32'h7F800000, 32'h00000000, {4'b1000, 32'h7FC00000}});
        vecs.push_back('{32'h00800000, 32'h00800000, {4'b0011, 32'h00000000}});
        vecs.push_back('{32'h00000001, 32'h3F800000, {4'b0000, 32'h00000000}});
        vecs.push_back('{32'h7FC00001, 32'h3F800000, {4'b0000, 32'h7FC00000}});
        vecs.push_back('{32'hFF800000, 32'h40000000, {4'b0000, 32'hFF800000}});
        vecs.push_back('{32'h80000000, 32'h3F800000, {4'b0000, 32'h80000000}});
        vecs.push_back('{32'hC0000000, 32'h40400000, {4'b0000, 32'hC0C00000}});
        vecs.push_back('{32'h00000000, 32'hFF800000, {4'b1000, 32'h7FC00000}});

        reset_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_flags", 64'(flags), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);

        foreach (vecs[i])
            single(vecs[i].a, vecs[i].b, vecs[i].want, $sformatf("vec%0d", i));

        // Five back-to-back ops with a 4-cycle stall at the first result
        sq_a.delete();
        sq_b.delete();
        for (int i = 0; i < 5; i++) begin
            sq_a.push_back(32'h3F800000 + 32'($urandom_range(0, 32'h7FFFFF)));
            sq_b.push_back(32'h40000000 + 32'($urandom_range(0, 32'h7FFFFF)));
        end
        run_stream(5, 1'b1);

        // Two ops in flight, then an asynchronous reset pulse
        out_ready = 1'b1;
        a = 32'h3FC00000;
        b = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'h40400000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_pre_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        saw_valid = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1;
        end
        check("rst_discard", 64'(saw_valid), 64'd0);
        single(32'hC0000000, 32'h40400000, {4'b0000, 32'hC0C00000}, "rst_after");

        // Randomized stream against the reference model
        sq_a.delete();
        sq_b.delete();
        for (int i = 0; i < 400; i++) begin
            sq_a.push_back(rand_op());
            sq_b.push_back(rand_op());
        end
        run_stream(400, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
